// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates one shared RAM port between the icache
// (single-word reads) and the dcache (single-word or burst reads/writes).
//
// Optional feature macro: ARB_FAIRNESS_EN
//   Undefined: strict dcache priority.
//   Defined:   after STARVE_LIMIT non-burst dcache completions while the
//              icache is waiting, the icache is granted next.
//
// Handshake: a requester holds its request (and address/data) high until
// its wait line drops for one cycle. That one low cycle is the completion
// of one word. wait stays high on FREE/BUSY/ERROR. After an ERROR, keeping
// the request high is the retry.
module mem_arbiter_ctrl #(
  parameter int WORD_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  input  logic              dburst,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  // A limit of zero would let the icache pre-empt the dcache unconditionally.
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter_ctrl: STARVE_LIMIT must be at least 1");
  end

  state_t state, next_state;
  logic   fair_pick;

  assign dbg_state = state;

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] fair_cnt;
  logic             d_single_done;

  // A non-burst dcache word completing while the icache is left waiting.
  assign d_single_done = (state == DGNT) && (ramstate == RAM_ACCESS) &&
                         (dREN || dWEN) && !dburst && iREN;

  assign fair_pick = (fair_cnt == CNT_MAX) && iREN;

  // Starvation counter: cleared when the icache is granted or stops asking.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fair_cnt <= '0;
    end else if ((state == IDLE && !iREN) || state == IGNT) begin
      fair_cnt <= '0;
    end else if (d_single_done && fair_cnt != CNT_MAX) begin
      fair_cnt <= fair_cnt + 1'b1;
    end
  end
`else
  assign fair_pick = 1'b0;
`endif

  // Grant state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and combinational RAM/cache outputs from the current grant.
  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    err        = 1'b0;

    case (state)
      IDLE: begin
        if (fair_pick) begin
          next_state = IGNT;
        end else if (dREN || dWEN) begin
          next_state = DGNT;
        end else if (iREN) begin
          next_state = IGNT;
        end
      end

      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait      = 1'b0;
          iload      = ramload;
          next_state = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          err        = 1'b1;
          next_state = IDLE;
        end
      end

      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dREN && !dWEN) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait      = 1'b0;
          dload      = dWEN ? '0 : ramload;
          next_state = dburst ? DGNT : IDLE;
        end else if (ramstate == RAM_ERROR) begin
          err        = 1'b1;
          next_state = IDLE;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed testbench for mem_arbiter_ctrl. Inputs change 1 ns after the
// rising edge; outputs are checked on the falling edge.
module tb_mem_arbiter_ctrl;

  localparam int W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IGNT = 2'd1;
  localparam logic [1:0] S_DGNT = 2'd2;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic         CLK;
  logic         nRST;
  logic         iREN;
  logic [W-1:0] iaddr;
  logic         iwait;
  logic [W-1:0] iload;
  logic         dREN;
  logic         dWEN;
  logic [W-1:0] daddr;
  logic [W-1:0] dstore;
  logic         dburst;
  logic         dwait;
  logic [W-1:0] dload;
  logic         ramREN;
  logic         ramWEN;
  logic [W-1:0] ramaddr;
  logic [W-1:0] ramstore;
  logic [W-1:0] ramload;
  logic [1:0]   ramstate;
  logic         err;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  mem_arbiter_ctrl #(.WORD_W(W), .STARVE_LIMIT(4)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dburst    (dburst),
    .dwait     (dwait),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Move to the falling edge where outputs are sampled.
  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with both requesters active.
    nRST = 1'b0; iREN = 1'b1; iaddr = '0; dREN = 1'b0; dWEN = 1'b1;
    daddr = '0; dstore = '0; dburst = 1'b0; ramload = '0; ramstate = FREE;
    settle();
    chk("rst_state", W'(dbg_state), W'(S_IDLE));
    chk("rst_iwait", W'(iwait), 1);
    chk("rst_dwait", W'(dwait), 1);
    chk("rst_ramren", W'(ramREN), 0);
    chk("rst_ramwen", W'(ramWEN), 0);
    chk("rst_err", W'(err), 0);
    chk("rst_ramaddr", ramaddr, 0);
    tick();
    nRST = 1'b1;
    settle();
    chk("rel_idle", W'(dbg_state), W'(S_IDLE));
    tick();
    settle();
    chk("rel_dgnt", W'(dbg_state), W'(S_DGNT));
    chk("rel_ramwen", W'(ramWEN), 1);
    chk("rel_ramren", W'(ramREN), 0);
    chk("rel_iwait", W'(iwait), 1);
    iREN = 1'b0; dWEN = 1'b0;
    tick();
    settle();
    chk("rel_back_idle", W'(dbg_state), W'(S_IDLE));

    // icache read with two BUSY cycles.
    iREN = 1'b1; iaddr = 32'h40;
    tick();
    ramstate = BUSY;
    settle();
    chk("ird_ignt", W'(dbg_state), W'(S_IGNT));
    chk("ird_ramren", W'(ramREN), 1);
    chk("ird_ramaddr", ramaddr, 32'h40);
    chk("ird_busy1_iwait", W'(iwait), 1);
    tick();
    settle();
    chk("ird_busy2_iwait", W'(iwait), 1);
    tick();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    settle();
    chk("ird_done_iwait", W'(iwait), 0);
    chk("ird_done_iload", iload, 32'hDEADBEEF);
    chk("ird_dwait", W'(dwait), 1);
    tick();
    iREN = 1'b0; ramstate = FREE;
    settle();
    chk("ird_after_idle", W'(dbg_state), W'(S_IDLE));
    chk("ird_after_iwait", W'(iwait), 1);
    chk("ird_after_iload", iload, 0);

    // Contention: dcache served first, one IDLE cycle, then icache.
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100;
    tick();
    ramstate = ACCESS; ramload = 32'h11112222;
    settle();
    chk("con_dgnt", W'(dbg_state), W'(S_DGNT));
    chk("con_ramaddr_d", ramaddr, 32'h100);
    chk("con_ramren_d", W'(ramREN), 1);
    chk("con_dwait", W'(dwait), 0);
    chk("con_dload", dload, 32'h11112222);
    chk("con_iwait_hold", W'(iwait), 1);
    tick();
    dREN = 1'b0; ramstate = FREE;
    settle();
    chk("con_idle", W'(dbg_state), W'(S_IDLE));
    chk("con_idle_dwait", W'(dwait), 1);
    tick();
    ramstate = ACCESS; ramload = 32'h33334444;
    settle();
    chk("con_ignt", W'(dbg_state), W'(S_IGNT));
    chk("con_ramaddr_i", ramaddr, 32'h80);
    chk("con_iwait", W'(iwait), 0);
    chk("con_iload", iload, 32'h33334444);
    tick();
    iREN = 1'b0; ramstate = FREE;
    settle();
    chk("con_end_idle", W'(dbg_state), W'(S_IDLE));

    // Two-word burst write.
    dWEN = 1'b1; dREN = 1'b1; dburst = 1'b1; daddr = 32'h200; dstore = 32'hA5A5A5A5;
    tick();
    ramstate = BUSY;
    settle();
    chk("bw_dgnt", W'(dbg_state), W'(S_DGNT));
    chk("bw_ramwen0", W'(ramWEN), 1);
    chk("bw_ramren0", W'(ramREN), 0);
    chk("bw_busy_dwait", W'(dwait), 1);
    tick();
    ramstate = ACCESS;
    settle();
    chk("bw_w0_dwait", W'(dwait), 0);
    chk("bw_w0_ramaddr", ramaddr, 32'h200);
    chk("bw_w0_ramstore", ramstore, 32'hA5A5A5A5);
    tick();
    daddr = 32'h204; dstore = 32'h5A5A5A5A; dburst = 1'b0;
    settle();
    chk("bw_w1_state", W'(dbg_state), W'(S_DGNT));
    chk("bw_w1_dwait", W'(dwait), 0);
    chk("bw_w1_ramaddr", ramaddr, 32'h204);
    chk("bw_w1_ramstore", ramstore, 32'h5A5A5A5A);
    chk("bw_w1_ramwen", W'(ramWEN), 1);
    chk("bw_w1_ramren", W'(ramREN), 0);
    tick();
    dWEN = 1'b0; dREN = 1'b0; ramstate = FREE;
    settle();
    chk("bw_end_idle", W'(dbg_state), W'(S_IDLE));

    // RAM error during an icache grant, then retry.
    iREN = 1'b1; iaddr = 32'hC0;
    tick();
    ramstate = ERROR;
    settle();
    chk("er_ignt", W'(dbg_state), W'(S_IGNT));
    chk("er_err", W'(err), 1);
    chk("er_iwait", W'(iwait), 1);
    tick();
    ramstate = FREE;
    settle();
    chk("er_idle", W'(dbg_state), W'(S_IDLE));
    chk("er_err_pulse", W'(err), 0);
    tick();
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    settle();
    chk("er_regrant", W'(dbg_state), W'(S_IGNT));
    chk("er_retry_iwait", W'(iwait), 0);
    chk("er_retry_iload", iload, 32'h0BADF00D);
    tick();
    iREN = 1'b0; ramstate = FREE;

    // Reset in the middle of a dcache read aborts without completion.
    dREN = 1'b1; daddr = 32'h300;
    tick();
    settle();
    chk("mr_dgnt", W'(dbg_state), W'(S_DGNT));
    tick();
    nRST = 1'b0; ramstate = ACCESS;
    settle();
    chk("mr_state", W'(dbg_state), W'(S_IDLE));
    chk("mr_dwait", W'(dwait), 1);
    chk("mr_ramren", W'(ramREN), 0);
    tick();
    nRST = 1'b1; dREN = 1'b0; ramstate = FREE;
    tick();

    // icache waits through five single-word dcache reads.
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; dburst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      daddr = W'(32'h400 + 4 * n);
      tick();
      ramstate = ACCESS; ramload = W'(32'h1000 + n);
`ifdef ARB_FAIRNESS_EN
      if (n == 4) begin
        settle();
        chk("fair_ignt", W'(dbg_state), W'(S_IGNT));
        chk("fair_iwait", W'(iwait), 0);
        chk("fair_iload", iload, W'(32'h1004));
        tick();
        ramstate = FREE;
        settle();
        chk("fair_idle", W'(dbg_state), W'(S_IDLE));
        tick();
        ramstate = ACCESS; ramload = W'(32'h1000 + n);
      end
`endif
      settle();
      chk($sformatf("sv_dgnt%0d", n), W'(dbg_state), W'(S_DGNT));
      chk($sformatf("sv_dwait%0d", n), W'(dwait), 0);
      chk($sformatf("sv_dload%0d", n), dload, W'(32'h1000 + n));
      chk($sformatf("sv_iwait%0d", n), W'(iwait), 1);
      tick();
      ramstate = FREE;
      if (n == 4) dREN = 1'b0;
      settle();
      chk($sformatf("sv_idle%0d", n), W'(dbg_state), W'(S_IDLE));
    end
    tick();
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    settle();
    chk("sv_final_ignt", W'(dbg_state), W'(S_IGNT));
    chk("sv_final_iwait", W'(iwait), 0);
    chk("sv_final_iload", iload, 32'hCAFE0001);
    tick();
    iREN = 1'b0; ramstate = FREE;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Sequences a single shared RAM port between the instruction cache (single-word reads) and the data cache (single-word or burst reads/writes).
- Sits between both caches and the memory/RAM interface.
- Registered grant FSM; data cache has priority; a grant is held for the whole dcache burst.
- Completion is signalled back to each cache by dropping its wait line for one cycle per word.

Parameters:
- WORD_W, 32, data and address width.
- STARVE_LIMIT, 4, consecutive dcache completions tolerated while icache waits (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- iREN  input  1  icache read request.
- iaddr  input  WORD_W  icache word address.
- iwait  output  1  low for exactly the completing cycle of an icache read.
- iload  output  WORD_W  icache read data, valid when iwait low.
- dREN  input  1  dcache read request.
- dWEN  input  1  dcache write request; wins over dREN if both high.
- daddr  input  WORD_W  dcache word address; the cache advances it between burst words.
- dstore  input  WORD_W  dcache write data.
- dburst  input  1  high: further words follow, keep the grant.
- dwait  output  1  low for exactly the completing cycle of each dcache word.
- dload  output  WORD_W  dcache read data, valid when dwait low.
- ramREN  output  1  RAM read enable.
- ramWEN  output  1  RAM write enable.
- ramaddr  output  WORD_W  RAM address.
- ramstore  output  WORD_W  RAM write data.
- ramload  input  WORD_W  RAM read data.
- ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (word done this cycle), 3 ERROR.
- err  output  1  one-cycle pulse on RAM ERROR.

Behaviour:
- Reset (async, nRST low):
  - state IDLE.
  - iwait=dwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0; iload=dload=0; err=0.
  - Fairness counter = 0.
- Reset mid-transfer aborts it immediately; no completion is signalled.
- States: IDLE, IGNT, DGNT (registered). RAM outputs are combinational from state and the granted requester's inputs. Outside its grant, each requester sees wait=1 and load=0.
- IDLE:
  - dREN|dWEN -> DGNT; else iREN -> IGNT; else stay.
  - No RAM access in IDLE, so minimum latency is request cycle + 1 grant cycle + RAM ACCESS.
- IGNT:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - ramstate==ACCESS: iwait=0, iload=ramload that cycle; next IDLE.
  - iREN dropped: next IDLE, no completion.
- DGNT:
  - ramWEN=dWEN; ramREN=dREN&~dWEN; ramaddr=daddr; ramstore=dstore.
  - ramstate==ACCESS: dwait=0, dload=ramload (reads). If dburst=1, stay in DGNT for the next word; else next IDLE.
  - dREN and dWEN both dropped: next IDLE.
- ramstate==ERROR in either grant:
  - err=1 for one cycle; wait stays 1; next IDLE.
  - Requester retries by keeping its request asserted.
- FREE/BUSY: wait stays 1 and the state holds.
- Simultaneous icache and dcache requests in IDLE: dcache granted. icache is re-arbitrated on return to IDLE.
- Back-to-back: after any completion the FSM passes through IDLE for one cycle, so no two completions occur in consecutive cycles except within a dcache burst.
- Address and data are passed through unmodified; no width arithmetic.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Defined:
  - A $clog2(STARVE_LIMIT+1)-bit counter increments on each dcache completion with dburst=0 while iREN=1.
  - It clears on icache grant or whenever iREN=0 in IDLE, and saturates at STARVE_LIMIT.
  - In IDLE with counter==STARVE_LIMIT and iREN=1, IGNT is chosen even if the dcache is requesting.
  - Bursts are never broken mid-block.
- Undefined: strict dcache priority; counter logic absent.

Test Plan:
- Reset: hold nRST=0 with iREN=1, dWEN=1 -> iwait=dwait=1, ramREN=ramWEN=0, err=0. Release: FSM in IDLE, dcache granted one cycle later.
- icache read: iREN=1, iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramaddr=0x40, iwait low exactly one cycle with iload=0xDEADBEEF.
- Contention: iREN and dREN both rise together; daddr=0x100 -> DGNT first, dcache completes, IDLE one cycle, then IGNT serves iaddr.
- Burst write: dWEN=1, dburst=1 for word 0x200 then dburst=0 for 0x204 -> two dwait low pulses, grant never leaves DGNT in between, ramWEN=1 and ramREN=0 throughout.
- Error: ramstate=3 during IGNT -> err=1 one cycle, iwait stays 1, FSM IDLE then regranted; next ACCESS completes normally.
- ARB_FAIRNESS_EN, STARVE_LIMIT=4: iREN held high with 5 single-word dcache requests back to back -> icache granted after the 4th dcache completion; 5th dcache request served after it.
